// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key code width, "no key" code and debounce FSM states
package keypad_pkg;
  localparam int KEY_W = 8;
  localparam logic [KEY_W-1:0] NONE_CODE = 8'h00;
  typedef enum logic [1:0] {IDLE, ARMING, HELD, RELEASING} state_t;
endpackage

// File: rtl/keypad_debounce_tick_counter.sv
// tick_counter: up-counter with sync clear (clear+inc loads 1) and terminal-count flag
module tick_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         tc
);
  logic [W-1:0] q;
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (clr) q <= W'(inc);
    else q <= q + W'(inc);
  assign tc = q == term;
endmodule

// File: rtl/keypad_debounce.sv
// keypad_debounce: tick-sampled key debouncer with press/release/auto-repeat pulses
module keypad_debounce #(
  parameter int W = keypad_pkg::KEY_W,
  parameter logic [W-1:0] NONE_CODE = W'(keypad_pkg::NONE_CODE),
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_TICKS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [W-1:0] code_in,
  output logic [W-1:0] code_out,
  output logic         key_down,
  output logic         press_pulse,
  output logic         release_pulse,
  output logic         repeat_pulse
);
  import keypad_pkg::*;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int RMAX = REPEAT_DELAY > REPEAT_TICKS ? REPEAT_DELAY : REPEAT_TICKS;
  localparam int RW = $clog2((RMAX > 1 ? RMAX : 1) + 1);
  localparam bit REP_EN = REPEAT_DELAY != 0;
  localparam bit ONE = DEBOUNCE_TICKS == 1;
  state_t state;
  logic [W-1:0] cand;
  logic rep_on, cnt_tc, rpt_tc;
  logic none, m_cand, m_out, press_now, rel_now, held_stay, cnt_keep, cnt_one;
  assign none = code_in == NONE_CODE;
  assign m_cand = code_in == cand;
  assign m_out = code_in == code_out;
  assign press_now = (state == ARMING && m_cand && cnt_tc) || (ONE && state == IDLE && !none);
  assign rel_now = !m_out && ((state == RELEASING && cnt_tc) || (ONE && state == HELD));
  assign held_stay = REP_EN && state == HELD && m_out;
  // keep counting a run of matching samples; otherwise restart at 1 or clear
  assign cnt_keep = !cnt_tc && ((state == ARMING && m_cand) || (state == RELEASING && !m_out));
  assign cnt_one = (!none && (state == IDLE || (state == ARMING && !m_cand))) || (state == HELD && !m_out);
  tick_counter #(.W(CW)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (tick && !cnt_keep),
    .inc (tick && (cnt_keep || cnt_one)),
    .term(CW'(DEBOUNCE_TICKS - 1)),
    .tc  (cnt_tc)
  );
  // rpt counts only ticks spent steadily in HELD, so a release bounce delays but never resets the schedule
  tick_counter #(.W(RW)) u_rpt (
    .clk (clk),
    .rst (rst),
    .clr (tick && (press_now || (held_stay && rpt_tc))),
    .inc (tick && held_stay && !rpt_tc),
    .term(rep_on ? RW'(REPEAT_TICKS - 1) : RW'(REPEAT_DELAY - 1)),
    .tc  (rpt_tc)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cand <= NONE_CODE;
      code_out <= NONE_CODE;
      rep_on <= 1'b0;
      key_down <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      press_pulse <= tick && press_now;
      release_pulse <= tick && rel_now;
      repeat_pulse <= tick && held_stay && rpt_tc;
      if (tick) begin
        if ((state == IDLE || state == ARMING) && !m_cand) cand <= code_in;
        if (press_now) begin
          state <= HELD;
          code_out <= code_in;
          key_down <= 1'b1;
          rep_on <= 1'b0;
        end else if (rel_now) begin
          state <= IDLE;
          code_out <= NONE_CODE;
          key_down <= 1'b0;
        end else
          case (state)
            IDLE: state <= none ? IDLE : ARMING;
            ARMING: state <= none ? IDLE : ARMING;
            HELD: begin
              state <= m_out ? HELD : RELEASING;
              rep_on <= rep_on || (held_stay && rpt_tc);
            end
            default: state <= m_out ? HELD : RELEASING;
          endcase
      end
    end
endmodule

// File: tb/tb_keypad_debounce.sv
// tb_keypad_debounce: directed self-checking bench for keypad_debounce (default parameters)
module tb_keypad_debounce;
  logic clk = 0, rst = 1, tick = 0;
  logic [7:0] code_in = 8'h00;
  logic [7:0] code_out;
  logic key_down, press_pulse, release_pulse, repeat_pulse;
  int total = 0, bad = 0;
  int np = 0, nr = 0, nrp = 0, nover = 0, sched_bad = 0;
  always #5 clk = ~clk;
  keypad_debounce dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .code_in      (code_in),
    .code_out     (code_out),
    .key_down     (key_down),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic zc();
    np = 0;
    nr = 0;
    nrp = 0;
  endtask
  task automatic tk(input logic [7:0] c);
    @(negedge clk);
    code_in = c;
    tick = 1;
    @(posedge clk);
    #1;
    tick = 0;
    np += int'(press_pulse);
    nr += int'(release_pulse);
    nrp += int'(repeat_pulse);
    if (int'(press_pulse) + int'(release_pulse) + int'(repeat_pulse) > 1) nover++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      np += int'(press_pulse);
      nr += int'(release_pulse);
      nrp += int'(repeat_pulse);
    end
  endtask
  initial begin
    tick = 1;
    code_in = 8'h12;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_code", code_out, 8'h00);
    chk("rst_pulses", {key_down, press_pulse, release_pulse, repeat_pulse}, 4'b0000);
    @(negedge clk);
    rst = 0;
    tick = 0;
    code_in = 8'h00;
    // clean press and release
    zc();
    repeat (3) tk(8'h12);
    chk("press_early", np, 0);
    chk("kd_early", key_down, 1'b0);
    tk(8'h12);
    chk("press_pulse", press_pulse, 1'b1);
    chk("press_code", code_out, 8'h12);
    chk("press_kd", key_down, 1'b1);
    idle(1);
    chk("press_one_clk", press_pulse, 1'b0);
    chk("kd_hold", key_down, 1'b1);
    zc();
    repeat (3) tk(8'h00);
    chk("rel_early", nr, 0);
    tk(8'h00);
    chk("rel_pulse", release_pulse, 1'b1);
    chk("rel_code", code_out, 8'h00);
    chk("rel_kd", key_down, 1'b0);
    // bounce on press
    zc();
    for (int i = 0; i < 10; i++) tk(i % 2 == 0 ? 8'h12 : 8'h00);
    repeat (3) tk(8'h12);
    chk("bounce_no_press", np, 0);
    tk(8'h12);
    chk("bounce_press", press_pulse, 1'b1);
    chk("bounce_press_cnt", np, 1);
    // release bounce keeps the repeat schedule: 10 held + bounce + 21 held, fire on the 22nd
    zc();
    repeat (10) tk(8'h12);
    tk(8'h00);
    tk(8'h00);
    tk(8'h12);
    chk("relb_no_rel", nr, 0);
    chk("relb_kd", key_down, 1'b1);
    chk("relb_code", code_out, 8'h12);
    repeat (21) tk(8'h12);
    chk("relb_no_rpt", nrp, 0);
    tk(8'h12);
    chk("relb_rpt", repeat_pulse, 1'b1);
    zc();
    repeat (4) tk(8'h00);
    chk("relb_release", nr, 1);
    // auto-repeat
    zc();
    repeat (4) tk(8'h21);
    chk("ar_press", np, 1);
    zc();
    for (int k = 1; k <= 60; k++) begin
      tk(8'h21);
      if (repeat_pulse !== (k >= 32 && (k - 32) % 8 == 0)) sched_bad++;
    end
    chk("ar_sched", sched_bad, 0);
    chk("ar_count", nrp, 4);
    zc();
    repeat (4) tk(8'h00);
    chk("ar_release", nr, 1);
    // rollover 12 -> 48
    repeat (4) tk(8'h12);
    chk("ro_code12", code_out, 8'h12);
    zc();
    repeat (3) tk(8'h48);
    chk("ro_no_rel", nr, 0);
    tk(8'h48);
    chk("ro_rel", release_pulse, 1'b1);
    chk("ro_rel_code", code_out, 8'h00);
    repeat (3) tk(8'h48);
    chk("ro_no_press", np, 0);
    chk("ro_kd_low", key_down, 1'b0);
    tk(8'h48);
    chk("ro_press", press_pulse, 1'b1);
    chk("ro_code48", code_out, 8'h48);
    chk("overlap", nover, 0);
    // reset mid-HELD with tick on the same edge
    @(negedge clk);
    rst = 1;
    tick = 1;
    code_in = 8'h00;
    @(posedge clk);
    #1;
    rst = 0;
    tick = 0;
    chk("mrst_out", {code_out, key_down, press_pulse, release_pulse, repeat_pulse}, 12'h000);
    zc();
    repeat (3) tk(8'h48);
    chk("mrst_no_press", np, 0);
    tk(8'h48);
    chk("mrst_press", press_pulse, 1'b1);
    // tick low: nothing moves
    zc();
    @(negedge clk);
    code_in = 8'h00;
    idle(10);
    chk("notick_rel", nr, 0);
    chk("notick_code", code_out, 8'h48);
    tk(8'h00);
    chk("releasing_kd", key_down, 1'b1);
    chk("releasing_no_rel", nr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_debounce.md
Name: keypad_debounce

Overview:
- Sits between the keypad scanner and the tone generator (wavegen).
- Samples the scanner's raw 8-bit key code on each slow scan tick and filters out bounce.
- Presents a stable key code with single-cycle press/release/repeat event pulses.
- Prevents wavegen from chirping on contact bounce.

Parameters:
- W, 8, key code width; matches the scanner output.
- NONE_CODE, 8'h00, code meaning "no key pressed".
- DEBOUNCE_TICKS, 4, consecutive equal tick samples required to accept a press or a release; legal range >=1.
- REPEAT_DELAY, 32, ticks in HELD before the first repeat_pulse; 0 disables repeat.
- REPEAT_TICKS, 8, ticks between subsequent repeat_pulses; must be >=1 when repeat is enabled.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-clk-wide scan-rate enable from clockdiv; all sampling is qualified by tick
- code_in  in  W  raw key code from the keypad scanner
- code_out  out  W  debounced key code; NONE_CODE when no key is accepted
- key_down  out  1  high while the FSM is in HELD or RELEASING
- press_pulse  out  1  one clk high when a press is accepted
- release_pulse  out  1  one clk high when a release is accepted
- repeat_pulse  out  1  one clk high on each auto-repeat interval

Behaviour:
- Reset (synchronous, active-high, sampled on rising clk):
  - state=IDLE; code_out=NONE_CODE; candidate=NONE_CODE; counters=0.
  - key_down and all pulse outputs are 0.
  - Reset mid-operation gives no release_pulse.
- State changes only on clk edges where tick=1; with tick=0 all state holds and all pulses are 0.
- Pulses are registered: they assert the clk after the qualifying tick edge and last exactly one clk.
- IDLE:
  - code_in==NONE_CODE: stay.
  - Otherwise: candidate<=code_in, cnt<=1, go to ARMING. If DEBOUNCE_TICKS==1, go straight to HELD with press.
- ARMING:
  - code_in==candidate: cnt++. When cnt reaches DEBOUNCE_TICKS: code_out<=candidate, press_pulse, go to HELD, cnt<=0, rpt<=0.
  - code_in==NONE_CODE: go to IDLE, no pulse.
  - code_in is a different non-NONE code: candidate<=code_in, cnt<=1, stay in ARMING.
- HELD:
  - code_in==code_out: stay. rpt++ handles auto-repeat:
    - First repeat_pulse fires when rpt reaches REPEAT_DELAY.
    - Thereafter one fires every REPEAT_TICKS ticks.
    - rpt saturates/reloads and never wraps into a spurious pulse.
  - Any other code_in (NONE or a different key): cnt<=1, go to RELEASING.
- RELEASING:
  - code_in!=code_out: cnt++. When cnt reaches DEBOUNCE_TICKS: release_pulse, code_out<=NONE_CODE, go to IDLE.
  - code_in==code_out (bounce): return to HELD with no pulse; rpt is preserved.
- Key rollover:
  - A second key held while the first is released goes through IDLE, then ARMING.
  - release_pulse for the old key always precedes press_pulse for the new key, at least one tick apart.
- Counter widths:
  - cnt is $clog2(DEBOUNCE_TICKS+1) bits.
  - rpt is $clog2(max(REPEAT_DELAY,REPEAT_TICKS)+1) bits.
  - Unsigned compares only; no overflow is possible.
- Simultaneous rst and tick: rst wins.
- At most one of press/release/repeat is high in any clk.
- key_down is registered and changes on the same clk as press_pulse/release_pulse.

Decomposition:
- Shared package (keypad_pkg) holds:
  - state enum {IDLE, ARMING, HELD, RELEASING}
  - NONE_CODE
  - key code width constant, shared with the scanner and wavegen.
- One natural sub-module: tick_counter, a tick-qualified up-counter with synchronous clear and terminal-count flag.
  - Instantiated twice: debounce cnt and repeat rpt.

Test Plan:
- Clean press, DEBOUNCE_TICKS=4: code_in=8'h12 held for 4 ticks -> press_pulse one clk after the 4th tick, code_out=8'h12, key_down=1; then NONE for 4 ticks -> release_pulse, code_out=8'h00, key_down=0.
- Bounce: code_in toggles 8'h12/8'h00 every tick for 10 ticks, then 8'h12 steady -> no pulse during toggling; exactly one press_pulse 4 ticks after it settles.
- Release bounce: in HELD, 2 ticks NONE then 8'h12 again -> no release_pulse, state HELD, and the repeat schedule is unchanged.
- Auto-repeat, REPEAT_DELAY=32, REPEAT_TICKS=8: hold 8'h21 for 60 ticks after press -> repeat_pulse at held ticks 32, 40, 48, 56; count=4.
- Rollover: HELD on 8'h12, code_in switches directly to 8'h48 -> release_pulse after 4 ticks, then press_pulse with code_out=8'h48 after 4 more ticks; never overlapping.
- Reset mid-HELD with tick high on the same edge -> next clk all outputs 0/NONE, no release_pulse; the subsequent press debounces from scratch.
